// File: rtl/psram_xfer_sched.sv
// PSRAM transaction scheduler: arbitrates two requesters and emits CMD/ADDR/WAIT/DATA beats to the PHY.
// Optional build macro PSRAM_SCHED_RR_EN selects round-robin arbitration (default: fixed priority, port 0 first).
module psram_xfer_sched #(
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    cfg_en_i,
  input  logic [7:0]              cfg_rdc_i,
  input  logic [7:0]              cfg_wrc_i,
  input  logic [7:0]              cfg_rdw_i,
  input  logic [7:0]              cfg_wrw_i,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [1:0]              req_we_i,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*LEN_WIDTH-1:0]  req_len_i,
  output logic                    phy_valid_o,
  input  logic                    phy_ready_i,
  output logic [1:0]              phy_phase_o,
  output logic [7:0]              phy_byte_o,
  output logic                    phy_last_o,
  output logic                    phy_ce_o,
  output logic [1:0]              gnt_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [2:0]              dbg_state_o
);
  localparam int NAB = ADDR_WIDTH / 8;
  localparam int CW  = LEN_WIDTH + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_END  = 3'd5;

  // Handshakes: a request is accepted in the cycle req_valid_i & req_ready_o are both high;
  // a PHY beat completes in the cycle phy_valid_o & phy_ready_i are both high, and beat
  // outputs hold steady until then.
  logic [2:0]            r_state;
  logic [1:0]            r_gnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [7:0]            r_op;
  logic [7:0]            r_wcnt;
  logic [CW-1:0]         r_cnt;

  logic                  w_grant;
  logic                  w_win;
  logic                  w_beat;
  logic                  w_active;
  logic                  w_we_sel;
  logic                  w_addr_last;
  logic                  w_data_last;
  logic [ADDR_WIDTH-1:0] w_addr_sel;
  logic [LEN_WIDTH-1:0]  w_len_sel;
  logic [7:0]            w_addr_byte;

`ifdef PSRAM_SCHED_RR_EN
  // r_ptr names the port that wins a tie; it flips to the other port on every grant.
  logic r_ptr;
  assign w_win = (&req_valid_i) ? r_ptr : req_valid_i[1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     r_ptr <= 1'b0;
    else if (w_grant) r_ptr <= ~w_win;
  end
`else
  assign w_win = ~req_valid_i[0];
`endif

  assign w_grant     = (r_state == S_IDLE) & cfg_en_i & (|req_valid_i);
  assign w_we_sel    = req_we_i[w_win];
  assign w_addr_sel  = w_win ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
  assign w_len_sel   = w_win ? req_len_i[2*LEN_WIDTH-1:LEN_WIDTH] : req_len_i[LEN_WIDTH-1:0];
  assign req_ready_o = w_grant ? (w_win ? 2'b10 : 2'b01) : 2'b00;

  assign w_active    = (r_state == S_CMD) | (r_state == S_ADDR) |
                       (r_state == S_WAIT) | (r_state == S_DATA);
  assign w_beat      = phy_valid_o & phy_ready_i;
  assign w_addr_last = (r_cnt == CW'(NAB - 1));
  assign w_data_last = (r_cnt == {1'b0, r_len});

  assign phy_valid_o = w_active;
  assign phy_ce_o    = ~w_active;
  assign phy_last_o  = (r_state == S_DATA) & w_data_last;
  assign gnt_o       = r_gnt;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_END);
  assign dbg_state_o = r_state;

  // Address beats go out MSB byte first: beat 0 carries the top byte.
  always_comb begin
    w_addr_byte = 8'h00;
    for (int i = 0; i < NAB; i++) begin
      if (r_cnt == CW'(NAB - 1 - i)) w_addr_byte = r_addr[i*8 +: 8];
    end
  end

  always_comb begin
    phy_phase_o = 2'b00;
    phy_byte_o  = 8'h00;
    case (r_state)
      S_CMD:  phy_byte_o  = r_op;
      S_ADDR: begin
        phy_phase_o = 2'b01;
        phy_byte_o  = w_addr_byte;
      end
      S_WAIT: phy_phase_o = 2'b10;
      S_DATA: phy_phase_o = 2'b11;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_gnt   <= 2'b00;
      r_addr  <= '0;
      r_len   <= '0;
      r_op    <= 8'h00;
      r_wcnt  <= 8'h00;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_state <= S_CMD;
          r_gnt   <= w_win ? 2'b10 : 2'b01;
          r_addr  <= {w_addr_sel[ADDR_WIDTH-1:1], 1'b0};
          // Writes move at least two bytes.
          r_len   <= (w_we_sel && w_len_sel == '0) ? LEN_WIDTH'(1) : w_len_sel;
          r_op    <= w_we_sel ? cfg_wrc_i : cfg_rdc_i;
          r_wcnt  <= w_we_sel ? cfg_wrw_i : cfg_rdw_i;
          r_cnt   <= '0;
        end
        S_CMD: if (w_beat) begin
          r_state <= S_ADDR;
          r_cnt   <= '0;
        end
        S_ADDR: if (w_beat) begin
          if (w_addr_last) begin
            r_state <= (r_wcnt == 8'h00) ? S_DATA : S_WAIT;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_WAIT: if (w_beat) begin
          r_wcnt <= r_wcnt - 8'h01;
          if (r_wcnt == 8'h01) r_state <= S_DATA;
        end
        S_DATA: if (w_beat) begin
          if (w_data_last) begin
            r_state <= S_END;
            r_gnt   <= 2'b00;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_END:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
